// File: rtl/ifu_fetch.sv
// ifu_fetch: holds PC and IR, fetching one instruction per request over a variable-latency memory handshake.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_wr,
    input  logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d, req_q;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  code_q, code_d;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        wait_cnt_d = wait_cnt_q;
        code_d     = code_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // pc_wr wins over a simultaneous fetch_start, which is dropped
                if (pc_wr) begin
                    pc_d = npc;
                end else if (fetch_start) begin
                    if (pc_q[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                        code_d  = 2'b01;
                    end else begin
                        state_d    = S_WAIT;
                        ir_valid_d = 1'b0;
                        wait_cnt_d = 8'd0;
                    end
                end
            end
            S_WAIT: begin
                if (imem_ready) begin
                    ir_d       = imem_rdata;
                    ir_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                    code_d  = 2'b10;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            ir_valid_q <= 1'b0;
            wait_cnt_q <= 8'd0;
            code_q     <= 2'b00;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            wait_cnt_q <= wait_cnt_d;
            code_q     <= code_d;
            req_q      <= state_d == S_WAIT;
        end
    end
    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign busy       = state_q == S_WAIT;
    assign fault      = state_q == S_FAULT;
    assign fault_code = code_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed plus randomized checks of ifu_fetch against a behavioural model.
module tb_ifu_fetch;
    localparam int TIMEOUT = 16;
    logic        clk = 1'b0;
    logic        rst = 1'b1, fetch_start = 1'b0, pc_wr = 1'b0, imem_ready = 1'b0;
    logic [31:0] npc = 32'd0, imem_rdata = 32'd0;
    logic        imem_req, ir_valid, busy, fault;
    logic [31:0] imem_addr, pc, ir;
    logic [1:0]  fault_code;
    int          n_chk = 0, n_fail = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_pc, m_ir;
    logic [1:0]  m_code;
    bit          m_irv, m_wait, m_fault;
    int          m_cyc;

    ifu_fetch #(.RESET_PC(32'h0000_3000), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_wr(pc_wr), .npc(npc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .pc(pc), .ir(ir), .ir_valid(ir_valid), .busy(busy),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a fetch is "in flight" for up to TIMEOUT cycles, counted from 1
    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0000_3000; m_ir = 0; m_irv = 0; m_wait = 0; m_fault = 0; m_code = 0; m_cyc = 0;
        end else if (m_fault) begin
        end else if (m_wait) begin
            m_cyc++;
            if (imem_ready) begin
                m_ir = imem_rdata; m_irv = 1; m_wait = 0;
            end else if (m_cyc == TIMEOUT) begin
                m_fault = 1; m_code = 2'b10; m_wait = 0;
            end
        end else if (pc_wr) begin
            m_pc = npc;
        end else if (fetch_start) begin
            if (m_pc % 4 != 0) begin
                m_fault = 1; m_code = 2'b01;
            end else begin
                m_wait = 1; m_irv = 0; m_cyc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("ir", ir, m_ir);
            chk("ir_valid", 32'(ir_valid), 32'(m_irv));
            chk("imem_req", 32'(imem_req), 32'(m_wait));
            chk("busy", 32'(busy), 32'(m_wait));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_code", 32'(fault_code), 32'(m_code));
        end
    end

    task automatic step(input logic rs, input logic fs, input logic pw, input logic [31:0] n,
                        input logic rdy, input logic [31:0] rd);
        rst = rs; fetch_start = fs; pc_wr = pw; npc = n; imem_ready = rdy; imem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        chk("rst pc", pc, 32'h0000_3000);
        chk("rst ir", ir, 0);
        chk("rst flags", {ir_valid, imem_req, busy, fault, fault_code}, 0);
        // three-cycle fetch
        step(0, 1, 0, 0, 0, 0);
        chk("fetch req", {imem_req, busy}, 2'b11);
        chk("fetch addr", imem_addr, 32'h0000_3000);
        idle(2);
        chk("fetch addr w2", imem_addr, 32'h0000_3000);
        step(0, 0, 0, 0, 1, 32'h0800_0C01);
        chk("fetch ir", ir, 32'h0800_0C01);
        chk("fetch done flags", {ir_valid, imem_req, busy}, 3'b100);
        // advance in DONE
        step(0, 0, 1, 32'h0000_3004, 0, 0);
        chk("adv pc", pc, 32'h0000_3004);
        chk("adv ir held", {ir, 31'd0, ir_valid}, {32'h0800_0C01, 32'd1});
        step(0, 1, 0, 0, 0, 0);
        chk("adv addr", imem_addr, 32'h0000_3004);
        chk("adv irv clr", {ir_valid, imem_req}, 2'b01);
        // pc_wr during WAIT ignored
        step(0, 0, 1, 32'h0000_4000, 0, 0);
        chk("wait pc_wr", pc, 32'h0000_3004);
        step(0, 0, 0, 0, 1, 32'h1234_5678);
        chk("second ir", ir, 32'h1234_5678);
        // timeout: no ready through WAIT cycle 16
        step(0, 1, 0, 0, 0, 0);
        idle(TIMEOUT - 1);
        chk("to before", {busy, fault}, 2'b10);
        idle(1);
        chk("to fault", {fault, fault_code, ir_valid}, 4'b1100);
        step(1, 0, 0, 0, 0, 0);
        // ready in WAIT cycle 16 still accepted
        step(0, 1, 0, 0, 0, 0);
        idle(TIMEOUT - 1);
        step(0, 0, 0, 0, 1, 32'hCAFE_F00D);
        chk("to edge ok", {fault, ir_valid}, 2'b01);
        chk("to edge ir", ir, 32'hCAFE_F00D);
        // pc_wr beats fetch_start in IDLE
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_3008, 0, 0);
        chk("pw+fs pc", pc, 32'h0000_3008);
        idle(1);
        chk("pw+fs no req", {imem_req, busy}, 0);
        // reset mid-WAIT, late ready ignored
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst wait", {imem_req, busy}, 0);
        chk("rst wait pc", pc, 32'h0000_3000);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("late ready", {ir, 31'd0, ir_valid}, 0);
        // misaligned PC
        step(0, 0, 1, 32'h0000_3006, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("mis fault", {fault, fault_code, imem_req}, 4'b1010);
        step(0, 0, 1, 32'h0000_3000, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("mis absorb", {pc[15:0], 13'd0, fault, fault_code}, {16'h3006, 16'h0005});
        // randomized
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] n;
            n = $urandom_range(0, 15) == 0 ? $urandom : {$urandom_range(0, 16'hFFFF), 2'b00};
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                 n, (i / 200) % 2 == 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 24) == 0,
                 $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the multi-cycle MIPS core. It holds the architectural PC and the instruction register (IR), and fetches one instruction from instruction memory per controller request over a variable-latency handshake. It sits directly upstream of the next-PC logic: `pc` feeds that stage's original-PC input, `ir` feeds its immediate/jump-field input and the decoder, and the computed next PC comes back on `npc` to be loaded on `pc_wr`.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `TIMEOUT`, default 16: maximum number of WAIT cycles without `imem_ready` before a fetch fault; legal range 2..255.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_start`  in  1  controller request: fetch the instruction at the current `pc`.
- `pc_wr`  in  1  load `npc` into `pc`.
- `npc`  in  32  next PC from the next-PC stage.
- `imem_req`  out  1  memory request; registered.
- `imem_addr`  out  32  fetch address; always equal to `pc`.
- `imem_ready`  in  1  memory response valid; `imem_rdata` is sampled in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  32  architectural PC.
- `ir`  out  32  instruction register.
- `ir_valid`  out  1  `ir` holds the instruction fetched from the current fetch.
- `busy`  out  1  high while in the WAIT state.
- `fault`  out  1  sticky fetch fault.
- `fault_code`  out  2  01 = misaligned PC, 10 = timeout, 00 = no fault.

## Operation
- Reset values: `pc` = `RESET_PC`; `ir` = 0; `ir_valid`, `imem_req`, `busy` and `fault` = 0; `fault_code` = 00; state = IDLE; `wait_cnt` = 0.
- The FSM has four states: IDLE, WAIT, DONE and FAULT. `busy` = (state == WAIT). `imem_req` is 1 exactly while in WAIT.
- IDLE or DONE, on `fetch_start` with `pc_wr` low:
  - If `pc[1:0]` != 0, go to FAULT with `fault_code` = 01. No request is ever issued.
  - Otherwise go to WAIT, clear `ir_valid` and clear `wait_cnt`.
- WAIT, priority order:
  - If `imem_ready` is high: `ir` <= `imem_rdata`, `ir_valid` <= 1, go to DONE.
  - Else if `wait_cnt` == `TIMEOUT`-1: go to FAULT with `fault_code` = 10; `ir` is unchanged and `ir_valid` stays 0.
  - Else `wait_cnt` increments by 1. `wait_cnt` is 8 bits wide.
- DONE: `ir` and `ir_valid` are held until the next accepted `fetch_start`.
- `pc_wr` is accepted in IDLE and DONE: `pc` <= `npc`. `ir` and `ir_valid` are unchanged; the IR keeps the current instruction while the PC advances.
- `pc_wr` is ignored in WAIT (the PC stays stable during a request) and in FAULT.
- If `pc_wr` and `fetch_start` are both high in IDLE or DONE, `pc_wr` wins. `fetch_start` is dropped and the controller must reissue it.
- FAULT is absorbing. `fetch_start` and `pc_wr` are ignored; only `rst` exits. `fault` = 1 and `fault_code` is held.
- `fetch_start` while in WAIT is ignored.

## Timing
- `fetch_start` sampled at edge N puts the block in WAIT with `imem_req` = 1 from edge N.
- `imem_ready` may arrive in the first WAIT cycle. The minimum fetch latency is therefore 2 edges from `fetch_start` to `ir_valid` = 1.
- `ir` and `ir_valid` update at the edge that samples `imem_ready`. `imem_req` drops at that same edge.
- Timeout boundary: `imem_ready` in WAIT cycle number `TIMEOUT` is still accepted. No ready in any of WAIT cycles 1..`TIMEOUT` gives FAULT at the edge ending cycle `TIMEOUT`.
- Misaligned fault: `fault` is set at the edge that samples `fetch_start`.
- `rst` during WAIT: at the reset edge `imem_req` drops and `pc` returns to `RESET_PC`. A late `imem_ready` arriving after reset is ignored.
- `imem_ready` outside WAIT is ignored.

## Test plan
- Reset: assert `rst` for 2 cycles, then release -> `pc` = 0x00003000, `ir` = 0, and `ir_valid`, `imem_req`, `busy`, `fault` and `fault_code` are all 0.
- Three-cycle fetch: `fetch_start` at cycle 0, `imem_ready` in the 3rd WAIT cycle with `imem_rdata` = 0x08000C01 -> `imem_addr` = 0x00003000 throughout; `ir` = 0x08000C01 and `ir_valid` = 1 after that edge; `imem_req` and `busy` drop at the same edge.
- Advance in DONE: `pc_wr` with `npc` = 0x00003004 -> `pc` = 0x00003004, while `ir` = 0x08000C01 and `ir_valid` = 1 are held. A following `fetch_start` drives `imem_addr` = 0x00003004 and clears `ir_valid`.
- Misaligned PC: `pc_wr` with `npc` = 0x00003006, then `fetch_start` -> `fault` = 1 and `fault_code` = 01 next edge, `imem_req` never rises. Further `pc_wr` and `fetch_start` have no effect until `rst`.
- Timeout with `TIMEOUT` = 16:
  - No `imem_ready` for 16 WAIT cycles -> `fault_code` = 10 and `ir_valid` = 0.
  - A repeat run with `imem_ready` in WAIT cycle 16 -> success, no fault.
- WAIT conflicts:
  - `pc_wr` with `npc` = 0x00004000 during WAIT -> `pc` is unchanged.
  - `pc_wr` together with `fetch_start` in IDLE -> `pc` loads and no request is issued.
  - `rst` mid-WAIT followed by `imem_ready` -> `ir` = 0 and `ir_valid` = 0.
